pipe_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding scoreboard for the pipelined MIPS core; replaces the fixed

---
 rtl/pipe_scoreboard_pkg.sv | 23 ++
 rtl/sb_match.sv | 31 +++
 rtl/pipe_scoreboard.sv | 139 +++++++++++++
 tb/tb_pipe_scoreboard.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_scoreboard_pkg.sv
// Shared constants and types for the pipeline hazard/forwarding scoreboard.
package pipe_scoreboard_pkg;

  // Stall-cycle counter width and its saturation ceiling.
  localparam int                  STALL_W   = 32;
  localparam logic [STALL_W-1:0]  STALL_MAX = '1;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_REGFILE = 0;

  // How one ID source operand is resolved against the in-flight writers.
  typedef enum logic [1:0] {
    SRC_REGFILE = 2'd0,  // no in-flight writer, or writer already in WB
    SRC_BYPASS  = 2'd1,  // youngest writer has its result ready to forward
    SRC_WAIT    = 2'd2   // youngest writer not ready yet: stall
  } src_kind_e;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] c);
    return (c == STALL_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Priority matcher: finds the youngest valid in-flight writer of one source register.
module sb_match #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CW     = 2,
  parameter int IW     = 2
) (
  input  logic [REG_AW-1:0]             src,
  input  logic [DEPTH-1:0]              v,
  input  logic [DEPTH-1:0][REG_AW-1:0]  rd,
  input  logic [DEPTH-1:0][CW-1:0]      cnt,
  output logic                          hit,
  output logic                          ready,
  output logic [IW-1:0]                 idx
);

  // Scan oldest to youngest so the lowest-index (youngest) match wins; r0 never matches.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((src != '0) && v[i] && (rd[i] == src)) begin
        hit   = 1'b1;
        ready = (cnt[i] == '0);
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight register writers across the post-ID
// stages, raises stall, and produces live and EX-registered forward selects.
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int FWD_EN   = 1,
  localparam int FSW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_regwrite,
  input  logic               id_memtoreg,
  output logic               hazard,
  output logic [FSW-1:0]     fwd_a,
  output logic [FSW-1:0]     fwd_b,
  output logic [FSW-1:0]     ex_fwd_a,
  output logic [FSW-1:0]     ex_fwd_b,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam int             CW       = $clog2(LOAD_LAT + 1);
  localparam int             IW       = $clog2(DEPTH);
  localparam logic [CW-1:0]  ALU_CNT  = CW'(ALU_LAT - 1);
  localparam logic [CW-1:0]  LOAD_CNT = CW'(LOAD_LAT - 1);

  // Per-stage in-flight writer entries: valid, destination, cycles until forwardable.
  logic [DEPTH-1:0]              v_q,   v_d;
  logic [DEPTH-1:0][REG_AW-1:0]  rd_q,  rd_d;
  logic [DEPTH-1:0][CW-1:0]      cnt_q, cnt_d;

  logic [FSW-1:0]     ex_fwd_a_q, ex_fwd_a_d;
  logic [FSW-1:0]     ex_fwd_b_q, ex_fwd_b_d;
  logic [STALL_W-1:0] stall_cycles_q, stall_cycles_d;

  logic               hit_a, rdy_a, hit_b, rdy_b;
  logic [IW-1:0]      idx_a, idx_b;
  src_kind_e          kind_a, kind_b;
  logic               issue, insert;

  // Countdown that stops at zero once the result is forwardable.
  function automatic logic [CW-1:0] sat0(input logic [CW-1:0] c);
    return (c == '0) ? c : c - CW'(1);
  endfunction

  // A writer in the last tracked stage is written back before ID reads the regfile.
  function automatic src_kind_e classify(input logic hit, input logic rdy,
                                         input logic [IW-1:0] idx);
    if (!hit || (idx == IW'(DEPTH - 1))) return SRC_REGFILE;
    if ((FWD_EN != 0) && rdy)            return SRC_BYPASS;
    return SRC_WAIT;
  endfunction

  sb_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CW(CW), .IW(IW)) u_match_a (
    .src   (id_rs),
    .v     (v_q),
    .rd    (rd_q),
    .cnt   (cnt_q),
    .hit   (hit_a),
    .ready (rdy_a),
    .idx   (idx_a)
  );

  sb_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CW(CW), .IW(IW)) u_match_b (
    .src   (id_rt),
    .v     (v_q),
    .rd    (rd_q),
    .cnt   (cnt_q),
    .hit   (hit_b),
    .ready (rdy_b),
    .idx   (idx_b)
  );

  // Resolve each operand into a forward select and the combined stall request.
  always_comb begin
    kind_a = classify(hit_a, rdy_a, idx_a);
    kind_b = classify(hit_b, rdy_b, idx_b);
    fwd_a  = (kind_a == SRC_BYPASS) ? FSW'(idx_a) + FSW'(1) : FSW'(FWD_REGFILE);
    fwd_b  = (kind_b == SRC_BYPASS) ? FSW'(idx_b) + FSW'(1) : FSW'(FWD_REGFILE);
    hazard = id_valid && !flush && ((kind_a == SRC_WAIT) || (kind_b == SRC_WAIT));
    issue  = id_valid && !hazard && !flush;
    insert = issue && id_regwrite && (id_rd != '0);
  end

  // Next state: shift the stage entries, enter the ID writer or a bubble, count stalls.
  always_comb begin
    v_d            = v_q;
    rd_d           = rd_q;
    cnt_d          = cnt_q;
    ex_fwd_a_d     = ex_fwd_a_q;
    ex_fwd_b_d     = ex_fwd_b_q;
    stall_cycles_d = stall_cycles_q;
    if (!hold) begin
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i]   = v_q[i-1];
        rd_d[i]  = rd_q[i-1];
        cnt_d[i] = sat0(cnt_q[i-1]);
      end
      v_d[0]   = insert;
      rd_d[0]  = id_rd;
      cnt_d[0] = insert ? (id_memtoreg ? LOAD_CNT : ALU_CNT) : '0;
      ex_fwd_a_d = issue ? fwd_a : FSW'(FWD_REGFILE);
      ex_fwd_b_d = issue ? fwd_b : FSW'(FWD_REGFILE);
      if (hazard) stall_cycles_d = sat_inc(stall_cycles_q);
    end
  end

  // State register; reset clears control state only and overrides hold.
  always_ff @(posedge clk) begin
    rd_q <= rd_d;
    if (reset) begin
      v_q            <= '0;
      cnt_q          <= '0;
      ex_fwd_a_q     <= '0;
      ex_fwd_b_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      v_q            <= v_d;
      cnt_q          <= cnt_d;
      ex_fwd_a_q     <= ex_fwd_a_d;
      ex_fwd_b_q     <= ex_fwd_b_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ex_fwd_a     = ex_fwd_a_q;
  assign ex_fwd_b     = ex_fwd_b_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Scoreboard bench: three scoreboard builds share one stimulus stream; each cycle the
// driver queues the expected outputs and a negedge monitor pops and compares them.
module tb_pipe_scoreboard;

  logic        clk;
  logic        reset, hold, flush;
  logic        id_valid, id_regwrite, id_memtoreg;
  logic [4:0]  id_rs, id_rt, id_rd;

  logic        hz0, hz1, hz2;
  logic [1:0]  fa0, fb0, efa0, efb0;
  logic [1:0]  fa1, fb1, efa1, efb1;
  logic [2:0]  fa2, fb2, efa2, efb2;
  logic [31:0] sc0, sc1, sc2;

  typedef struct {
    string  name;
    int     inst;
    int     hz;
    int     fa;
    int     fb;
    int     efa;
    int     efb;
    longint sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam longint SC_FE = 64'h0000_0000_FFFF_FFFE;
  localparam longint SC_FF = 64'h0000_0000_FFFF_FFFF;

  pipe_scoreboard u0 (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .hazard(hz0), .fwd_a(fa0), .fwd_b(fb0),
    .ex_fwd_a(efa0), .ex_fwd_b(efb0), .stall_cycles(sc0)
  );

  pipe_scoreboard #(.FWD_EN(0)) u1 (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .hazard(hz1), .fwd_a(fa1), .fwd_b(fb1),
    .ex_fwd_a(efa1), .ex_fwd_b(efb1), .stall_cycles(sc1)
  );

  pipe_scoreboard #(.DEPTH(4), .LOAD_LAT(3)) u2 (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .hazard(hz2), .fwd_a(fa2), .fwd_b(fb2),
    .ex_fwd_a(efa2), .ex_fwd_b(efb2), .stall_cycles(sc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input string name, input int inst, input int hz,
                              input int fa, input int fb, input int efa, input int efb,
                              input longint sc);
    exp_t e;
    e.name = name; e.inst = inst; e.hz = hz; e.fa = fa; e.fb = fb;
    e.efa = efa; e.efb = efb; e.sc = sc;
    return e;
  endfunction

  // Field selector: 0 hazard, 1 fwd_a, 2 fwd_b, 3 ex_fwd_a, 4 ex_fwd_b, 5 stall_cycles.
  function automatic longint obs(input int inst, input int f);
    longint r;
    r = 0;
    case (inst)
      0: case (f) 0: r = hz0; 1: r = fa0; 2: r = fb0; 3: r = efa0; 4: r = efb0;
                  default: r = sc0; endcase
      1: case (f) 0: r = hz1; 1: r = fa1; 2: r = fb1; 3: r = efa1; 4: r = efb1;
                  default: r = sc1; endcase
      default: case (f) 0: r = hz2; 1: r = fa2; 2: r = fb2; 3: r = efa2; 4: r = efb2;
                  default: r = sc2; endcase
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input string field, input longint expv,
                     input longint act);
    if (expv < 0) return;
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, expv);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "hazard",       e.hz,  obs(e.inst, 0));
      chk(e.name, "fwd_a",        e.fa,  obs(e.inst, 1));
      chk(e.name, "fwd_b",        e.fb,  obs(e.inst, 2));
      chk(e.name, "ex_fwd_a",     e.efa, obs(e.inst, 3));
      chk(e.name, "ex_fwd_b",     e.efb, obs(e.inst, 4));
      chk(e.name, "stall_cycles", e.sc,  obs(e.inst, 5));
    end
  end

  task automatic set_id(input logic v, input int rs, input int rt, input int rd,
                        input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_rd       = 5'(rd);
    id_regwrite = rw;
    id_memtoreg = mr;
  endtask

  task automatic add_exp(input exp_t e);
    exp_q.push_back(e);
  endtask

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    add_exp(mk("rst_u1", 1, 0, 0, 0, 0, 0, 0));
    add_exp(mk("rst_u2", 2, 0, 0, 0, 0, 0, 0));
    step(mk("rst_u0", 0, 0, 0, 0, 0, 0, 0));

    // ALU writer followed by a dependent: forward from EX output, no stall
    set_id(1, 1, 2, 3, 1, 0);  step(mk("alu_wr", 0, 0, 0, 0, -1, -1, -1));
    set_id(1, 3, 3, 4, 1, 0);  step(mk("alu_dep", 0, 0, 1, 1, 0, 0, -1));
    set_id(0, 0, 0, 0, 0, 0);  step(mk("alu_ex", 0, 0, -1, -1, 1, 1, 0));

    // Load-use: one stall, then forward from MEM output
    set_id(1, 1, 2, 5, 1, 1);  step(mk("ld_wr", 0, 0, 0, 0, 0, 0, 0));
    set_id(1, 5, 1, 6, 1, 0);  step(mk("ld_stall", 0, 1, 0, -1, 0, 0, 0));
                               step(mk("ld_fwd", 0, 0, 2, 0, 0, 0, 1));
    set_id(0, 0, 0, 0, 0, 0);  step(mk("ld_ex", 0, 0, -1, -1, 2, 0, 1));

    // r0 is never tracked; two writers of r8 resolve to the youngest
    set_id(1, 1, 2, 0, 1, 0);  step(mk("r0_wr", 0, 0, 0, 0, -1, -1, -1));
    set_id(1, 0, 0, 11, 0, 0); step(mk("r0_use", 0, 0, 0, 0, -1, -1, -1));
    set_id(1, 1, 2, 8, 1, 0);  step(mk("r8_old", 0, 0, 0, 0, -1, -1, -1));
    set_id(1, 1, 2, 8, 1, 0);  step(mk("r8_new", 0, 0, 0, 0, -1, -1, -1));
    set_id(1, 8, 8, 9, 1, 0);  step(mk("r8_young", 0, 0, 1, 1, -1, -1, -1));
    set_id(0, 0, 0, 0, 0, 0);  step(mk("r8_gap", 0, 0, -1, -1, 1, 1, -1));
    set_id(1, 8, 9, 10, 0, 0); step(mk("wb_regfile", 0, 0, 0, 2, -1, -1, -1));

    // Flush beats a load-use hazard and inserts a bubble
    set_id(1, 1, 2, 5, 1, 1);  step(mk("fl_ld", 0, 0, 0, 0, -1, -1, 1));
    set_id(1, 5, 2, 10, 1, 0); flush = 1'b1;
                               step(mk("fl_cycle", 0, 0, -1, -1, -1, -1, 1));
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0);  step(mk("fl_after", 0, 0, -1, -1, 0, 0, 1));
    set_id(1, 10, 2, 12, 0, 0); step(mk("fl_bubble", 0, 0, 0, 0, -1, -1, 1));

    // Hold freezes entries and the stall counter while hazard stays visible
    set_id(1, 1, 2, 11, 1, 1); step(mk("hd_ld", 0, 0, 0, 0, -1, -1, 1));
    set_id(1, 11, 2, 13, 1, 0); hold = 1'b1;
                               step(mk("hd_1", 0, 1, -1, -1, -1, -1, 1));
                               step(mk("hd_2", 0, 1, -1, -1, -1, -1, 1));
                               step(mk("hd_3", 0, 1, -1, -1, -1, -1, 1));
    hold = 1'b0;               step(mk("hd_stall", 0, 1, 0, -1, -1, -1, 1));
                               step(mk("hd_go", 0, 0, 2, 0, -1, -1, 2));

    // Reset in the middle of a stall (with hold asserted) clears everything
    set_id(1, 1, 2, 12, 1, 1); step(mk("rs_ld", 0, 0, 0, 0, -1, -1, 2));
    set_id(1, 12, 2, 6, 1, 0); hold = 1'b1; reset = 1'b1;
                               step(mk("rs_cycle", 0, 1, -1, -1, -1, -1, -1));
    hold = 1'b0; reset = 1'b0; step(mk("rs_after", 0, 0, 0, 0, 0, 0, 0));

    // Stall counter saturation
    set_id(0, 0, 0, 0, 0, 0);
    force u0.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release u0.stall_cycles_q;
                               step(mk("sat_preset", 0, 0, -1, -1, -1, -1, SC_FE));
    set_id(1, 1, 2, 13, 1, 1); step(mk("sat_ld1", 0, 0, -1, -1, -1, -1, SC_FE));
    set_id(1, 13, 2, 14, 1, 0); step(mk("sat_st1", 0, 1, -1, -1, -1, -1, SC_FE));
                               step(mk("sat_top", 0, 0, 2, -1, -1, -1, SC_FF));
    set_id(1, 1, 2, 15, 1, 1); step(mk("sat_ld2", 0, 0, -1, -1, -1, -1, SC_FF));
    set_id(1, 15, 2, 16, 1, 0); step(mk("sat_st2", 0, 1, -1, -1, -1, -1, SC_FF));
                               step(mk("sat_hold", 0, 0, 2, -1, -1, -1, SC_FF));

    // Stall-only build: ALU dependent waits two cycles, then reads the regfile
    reset = 1'b1; set_id(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    add_exp(mk("rst2_u1", 1, 0, 0, 0, 0, 0, 0));
    step(mk("rst2_u2", 2, 0, 0, 0, 0, 0, 0));
    set_id(1, 1, 3, 2, 1, 0);  step(mk("nf_wr", 1, 0, 0, 0, -1, -1, 0));
    set_id(1, 2, 0, 7, 1, 0);  step(mk("nf_s1", 1, 1, 0, 0, -1, -1, 0));
                               step(mk("nf_s2", 1, 1, 0, 0, -1, -1, 1));
                               step(mk("nf_go", 1, 0, 0, 0, -1, -1, 2));
    set_id(0, 0, 0, 0, 0, 0);  step(mk("nf_ex", 1, 0, -1, -1, 0, 0, 2));

    // Four-stage build with three-cycle loads: two stalls, then forward select 3
    set_id(1, 1, 3, 5, 1, 1);  step(mk("d4_ld", 2, 0, 0, 0, -1, -1, 0));
    set_id(1, 5, 3, 8, 1, 0);  step(mk("d4_s1", 2, 1, 0, -1, -1, -1, 0));
                               step(mk("d4_s2", 2, 1, 0, -1, -1, -1, 1));
                               step(mk("d4_go", 2, 0, 3, 0, -1, -1, 2));
    set_id(0, 0, 0, 0, 0, 0);  step(mk("d4_ex", 2, 0, -1, -1, 3, 0, 2));

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
